// File: rtl/taxi_axil_if.sv
// AXI4-Lite bundle shared by the arbiter ports.
// Modports: wr_mst/wr_slv (AW, W, B), rd_mst/rd_slv (AR, R).
interface taxi_axil_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int STRB_W = DATA_W / 8
) ();
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport wr_mst (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport wr_slv (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );

  modport rd_mst (
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport rd_slv (
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );
endinterface

// File: rtl/taxi_axil_arb_2to1.sv
// 2:1 AXI4-Lite arbiter, independent write/read channels, one txn each.
// Ports: clk, rst_n, s0/s1 wr+rd slaves, m wr+rd master, wr_grant, rd_grant, busy.
module taxi_axil_arb_2to1 #(
  parameter int ARB_RR = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  taxi_axil_if.wr_slv s0_axil_wr,
  taxi_axil_if.rd_slv s0_axil_rd,
  taxi_axil_if.wr_slv s1_axil_wr,
  taxi_axil_if.rd_slv s1_axil_rd,
  taxi_axil_if.wr_mst m_axil_wr,
  taxi_axil_if.rd_mst m_axil_rd,
  output logic [1:0]  wr_grant,
  output logic [1:0]  rd_grant,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_RESP
  } st_e;

  // Assert follows rst_n at once; release is retimed to clk.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_int_n;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_int_n = rst_sync_q[1];

  // Both requesting: the port not served last wins under RR.
  function automatic logic [1:0] pick(
    input logic [1:0] req,
    input logic       last
  );
    if (req == 2'b11)
      pick = (ARB_RR != 0 && !last) ? 2'b10 : 2'b01;
    else
      pick = req;
  endfunction

  // ---------------- write channel ----------------
  st_e        wr_st_q, wr_st_d;
  logic [1:0] wr_grant_q, wr_grant_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
  logic       wr_last_q, wr_last_d;
  logic       wr_sel;
  logic [1:0] wr_req;
  logic       sel_awvalid, sel_wvalid;
  logic       aw_hs, w_hs, b_hs;

  assign wr_sel = wr_grant_q[1];
  assign wr_req = {s1_axil_wr.awvalid, s0_axil_wr.awvalid};
  assign sel_awvalid = wr_sel ? s1_axil_wr.awvalid
                              : s0_axil_wr.awvalid;
  assign sel_wvalid  = wr_sel ? s1_axil_wr.wvalid
                              : s0_axil_wr.wvalid;

  assign aw_hs = m_axil_wr.awvalid & m_axil_wr.awready;
  assign w_hs  = m_axil_wr.wvalid & m_axil_wr.wready;
  assign b_hs  = m_axil_wr.bvalid & m_axil_wr.bready;

  always_comb begin
    m_axil_wr.awaddr  = wr_sel ? s1_axil_wr.awaddr
                               : s0_axil_wr.awaddr;
    m_axil_wr.awprot  = wr_sel ? s1_axil_wr.awprot
                               : s0_axil_wr.awprot;
    m_axil_wr.wdata   = wr_sel ? s1_axil_wr.wdata
                               : s0_axil_wr.wdata;
    m_axil_wr.wstrb   = wr_sel ? s1_axil_wr.wstrb
                               : s0_axil_wr.wstrb;
    m_axil_wr.awvalid = 1'b0;
    m_axil_wr.wvalid  = 1'b0;
    m_axil_wr.bready  = 1'b0;
    s0_axil_wr.awready = 1'b0;
    s0_axil_wr.wready  = 1'b0;
    s0_axil_wr.bvalid  = 1'b0;
    s0_axil_wr.bresp   = '0;
    s1_axil_wr.awready = 1'b0;
    s1_axil_wr.wready  = 1'b0;
    s1_axil_wr.bvalid  = 1'b0;
    s1_axil_wr.bresp   = '0;
    if (wr_st_q == ST_ADDR) begin
      m_axil_wr.awvalid = sel_awvalid & ~aw_done_q;
      m_axil_wr.wvalid  = sel_wvalid & ~w_done_q;
      if (wr_sel) begin
        s1_axil_wr.awready = m_axil_wr.awready & ~aw_done_q;
        s1_axil_wr.wready  = m_axil_wr.wready & ~w_done_q;
      end else begin
        s0_axil_wr.awready = m_axil_wr.awready & ~aw_done_q;
        s0_axil_wr.wready  = m_axil_wr.wready & ~w_done_q;
      end
    end
    if (wr_st_q == ST_RESP) begin
      m_axil_wr.bready = wr_sel ? s1_axil_wr.bready
                                : s0_axil_wr.bready;
      if (wr_sel) begin
        s1_axil_wr.bvalid = m_axil_wr.bvalid;
        s1_axil_wr.bresp  = m_axil_wr.bresp;
      end else begin
        s0_axil_wr.bvalid = m_axil_wr.bvalid;
        s0_axil_wr.bresp  = m_axil_wr.bresp;
      end
    end
  end

  always_comb begin
    wr_st_d    = wr_st_q;
    wr_grant_d = wr_grant_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    wr_last_d  = wr_last_q;
    unique case (wr_st_q)
      ST_IDLE: begin
        if (|wr_req) begin
          wr_grant_d = pick(wr_req, wr_last_q);
          wr_st_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          wr_st_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (b_hs) begin
          wr_grant_d = 2'b00;
          wr_last_d  = wr_sel;
          wr_st_d    = ST_IDLE;
        end
      end
      default: wr_st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      wr_st_q    <= ST_IDLE;
      wr_grant_q <= 2'b00;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      wr_last_q  <= 1'b1;
    end else begin
      wr_st_q    <= wr_st_d;
      wr_grant_q <= wr_grant_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      wr_last_q  <= wr_last_d;
    end
  end

  // ---------------- read channel ----------------
  st_e        rd_st_q, rd_st_d;
  logic [1:0] rd_grant_q, rd_grant_d;
  logic       rd_last_q, rd_last_d;
  logic       rd_sel;
  logic [1:0] rd_req;
  logic       ar_hs, r_hs;

  assign rd_sel = rd_grant_q[1];
  assign rd_req = {s1_axil_rd.arvalid, s0_axil_rd.arvalid};
  assign ar_hs  = m_axil_rd.arvalid & m_axil_rd.arready;
  assign r_hs   = m_axil_rd.rvalid & m_axil_rd.rready;

  always_comb begin
    m_axil_rd.araddr  = rd_sel ? s1_axil_rd.araddr
                               : s0_axil_rd.araddr;
    m_axil_rd.arprot  = rd_sel ? s1_axil_rd.arprot
                               : s0_axil_rd.arprot;
    m_axil_rd.arvalid = 1'b0;
    m_axil_rd.rready  = 1'b0;
    s0_axil_rd.arready = 1'b0;
    s0_axil_rd.rvalid  = 1'b0;
    s0_axil_rd.rdata   = '0;
    s0_axil_rd.rresp   = '0;
    s1_axil_rd.arready = 1'b0;
    s1_axil_rd.rvalid  = 1'b0;
    s1_axil_rd.rdata   = '0;
    s1_axil_rd.rresp   = '0;
    if (rd_st_q == ST_ADDR) begin
      m_axil_rd.arvalid = rd_sel ? s1_axil_rd.arvalid
                                 : s0_axil_rd.arvalid;
      if (rd_sel) s1_axil_rd.arready = m_axil_rd.arready;
      else        s0_axil_rd.arready = m_axil_rd.arready;
    end
    if (rd_st_q == ST_RESP) begin
      m_axil_rd.rready = rd_sel ? s1_axil_rd.rready
                                : s0_axil_rd.rready;
      if (rd_sel) begin
        s1_axil_rd.rvalid = m_axil_rd.rvalid;
        s1_axil_rd.rdata  = m_axil_rd.rdata;
        s1_axil_rd.rresp  = m_axil_rd.rresp;
      end else begin
        s0_axil_rd.rvalid = m_axil_rd.rvalid;
        s0_axil_rd.rdata  = m_axil_rd.rdata;
        s0_axil_rd.rresp  = m_axil_rd.rresp;
      end
    end
  end

  always_comb begin
    rd_st_d    = rd_st_q;
    rd_grant_d = rd_grant_q;
    rd_last_d  = rd_last_q;
    unique case (rd_st_q)
      ST_IDLE: begin
        if (|rd_req) begin
          rd_grant_d = pick(rd_req, rd_last_q);
          rd_st_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (ar_hs) rd_st_d = ST_RESP;
      end
      ST_RESP: begin
        if (r_hs) begin
          rd_grant_d = 2'b00;
          rd_last_d  = rd_sel;
          rd_st_d    = ST_IDLE;
        end
      end
      default: rd_st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      rd_st_q    <= ST_IDLE;
      rd_grant_q <= 2'b00;
      rd_last_q  <= 1'b1;
    end else begin
      rd_st_q    <= rd_st_d;
      rd_grant_q <= rd_grant_d;
      rd_last_q  <= rd_last_d;
    end
  end

  assign wr_grant = wr_grant_q;
  assign rd_grant = rd_grant_q;
  assign busy     = (|wr_grant_q) | (|rd_grant_q);

endmodule

// File: tb/tb_taxi_axil_arb_2to1.sv
// Random two-master traffic against a transaction-level model.
// Checks grants, routing, isolation, payloads and reset.
module tb_taxi_axil_arb_2to1;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] wr_grant, rd_grant;
  logic       busy;

  always #5 clk = ~clk;

  taxi_axil_if #(.DATA_W(32), .ADDR_W(32)) s0_if ();
  taxi_axil_if #(.DATA_W(32), .ADDR_W(32)) s1_if ();
  taxi_axil_if #(.DATA_W(32), .ADDR_W(32)) m_if ();

  taxi_axil_arb_2to1 #(.ARB_RR(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s0_axil_wr (s0_if),
    .s0_axil_rd (s0_if),
    .s1_axil_wr (s1_if),
    .s1_axil_rd (s1_if),
    .m_axil_wr  (m_if),
    .m_axil_rd  (m_if),
    .wr_grant   (wr_grant),
    .rd_grant   (rd_grant),
    .busy       (busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] bresp_of(input logic [31:0] a);
    return a[5:4];
  endfunction
  function automatic logic [1:0] rresp_of(input logic [31:0] a);
    return a[7:6];
  endfunction
  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return a ^ 32'h5a5a_a5a5;
  endfunction
  // Both asking: the port not served last goes next.
  function automatic logic [1:0] winner(input logic [1:0] req,
                                        input logic last);
    if (req == 2'b11) return last ? 2'b01 : 2'b10;
    return req;
  endfunction

  // master-side state, per port
  logic [1:0]  w_act, w_awv, w_wv, w_awd, w_wd, w_bry;
  logic [31:0] w_addr [2];
  logic [31:0] w_data [2];
  logic [3:0]  w_strb [2];
  logic [2:0]  w_prot [2];
  int          w_awdly [2];
  int          w_wdly [2];
  int          w_iss [2];
  int          w_cmp [2];
  logic [1:0]  r_act, r_arv, r_ard, r_rry;
  logic [31:0] r_addr [2];
  logic [2:0]  r_prot [2];
  int          r_ardly [2];
  int          r_iss [2];
  int          r_cmp [2];
  // slave-side state
  logic        sw_aw, sw_w, sw_bv, sw_awr, sw_wr, sw_hold;
  logic [31:0] sw_addr;
  logic        sr_ar, sr_rv, sr_arr;
  logic [31:0] sr_addr;
  // arbitration model
  logic [1:0]  pwg, pwreq, prg, prreq;
  logic        pbhs, prhs, lw, lr;
  logic        gen_on;
  // per-cycle observations
  logic [1:0]  s_awr, s_wr, s_bv, s_arr, s_rv;
  logic [1:0]  s_bresp [2];
  logic [1:0]  s_rresp [2];
  logic [31:0] s_rdata [2];
  logic [1:0]  hs_aw, hs_w, hs_b, hs_ar, hs_r;
  logic        mhs_aw, mhs_w, mhs_b, mhs_ar, mhs_r;
  logic [31:0] cap_aw, cap_ar;

  task automatic reset_model();
    w_act = 0; w_awv = 0; w_wv = 0; w_awd = 0; w_wd = 0; w_bry = 0;
    r_act = 0; r_arv = 0; r_ard = 0; r_rry = 0;
    for (int p = 0; p < 2; p++) begin
      w_addr[p] = 0; w_data[p] = 0; w_strb[p] = 0; w_prot[p] = 0;
      r_addr[p] = 0; r_prot[p] = 0;
      w_awdly[p] = 0; w_wdly[p] = 0; r_ardly[p] = 0;
    end
    hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
    mhs_aw = 0; mhs_w = 0; mhs_b = 0; mhs_ar = 0; mhs_r = 0;
    sw_aw = 0; sw_w = 0; sw_bv = 0; sw_awr = 0; sw_wr = 0;
    sw_addr = 0; sr_ar = 0; sr_rv = 0; sr_arr = 0; sr_addr = 0;
    pwg = 0; pwreq = 0; prg = 0; prreq = 0; pbhs = 0; prhs = 0;
    lw = 1; lr = 1;
  endtask

  task automatic drive();
    s0_if.awaddr = w_addr[0]; s0_if.awprot = w_prot[0];
    s0_if.awvalid = w_awv[0]; s0_if.wdata = w_data[0];
    s0_if.wstrb = w_strb[0]; s0_if.wvalid = w_wv[0];
    s0_if.bready = w_bry[0]; s0_if.araddr = r_addr[0];
    s0_if.arprot = r_prot[0]; s0_if.arvalid = r_arv[0];
    s0_if.rready = r_rry[0];
    s1_if.awaddr = w_addr[1]; s1_if.awprot = w_prot[1];
    s1_if.awvalid = w_awv[1]; s1_if.wdata = w_data[1];
    s1_if.wstrb = w_strb[1]; s1_if.wvalid = w_wv[1];
    s1_if.bready = w_bry[1]; s1_if.araddr = r_addr[1];
    s1_if.arprot = r_prot[1]; s1_if.arvalid = r_arv[1];
    s1_if.rready = r_rry[1];
    m_if.awready = sw_awr; m_if.wready = sw_wr;
    m_if.bvalid = sw_bv; m_if.bresp = bresp_of(sw_addr);
    m_if.arready = sr_arr; m_if.rvalid = sr_rv;
    m_if.rdata = rdata_of(sr_addr); m_if.rresp = rresp_of(sr_addr);
  endtask

  task automatic start_wr(input int p, input int da, input int dw);
    w_act[p] = 1; w_awd[p] = 0; w_wd[p] = 0;
    w_awv[p] = 0; w_wv[p] = 0;
    w_addr[p] = $urandom & 32'hffff_fffc;
    w_data[p] = $urandom;
    w_strb[p] = 4'($urandom_range(15));
    w_prot[p] = 3'($urandom_range(7));
    w_awdly[p] = da; w_wdly[p] = dw;
    w_iss[p]++;
  endtask

  task automatic start_rd(input int p, input int da);
    r_act[p] = 1; r_ard[p] = 0; r_arv[p] = 0;
    r_addr[p] = $urandom & 32'hffff_fffc;
    r_prot[p] = 3'($urandom_range(7));
    r_ardly[p] = da;
    r_iss[p]++;
  endtask

  task automatic advance();
    for (int p = 0; p < 2; p++) begin
      if (w_act[p] && !w_awd[p] && !w_awv[p]) begin
        if (w_awdly[p] == 0) w_awv[p] = 1;
        else w_awdly[p]--;
      end
      if (w_act[p] && !w_wd[p] && !w_wv[p]) begin
        if (w_wdly[p] == 0) w_wv[p] = 1;
        else w_wdly[p]--;
      end
      if (r_act[p] && !r_ard[p] && !r_arv[p]) begin
        if (r_ardly[p] == 0) r_arv[p] = 1;
        else r_ardly[p]--;
      end
      w_bry[p] = $urandom_range(3) != 0;
      r_rry[p] = $urandom_range(3) != 0;
    end
  endtask

  task automatic sample();
    s_awr = {s1_if.awready, s0_if.awready};
    s_wr  = {s1_if.wready, s0_if.wready};
    s_bv  = {s1_if.bvalid, s0_if.bvalid};
    s_arr = {s1_if.arready, s0_if.arready};
    s_rv  = {s1_if.rvalid, s0_if.rvalid};
    s_bresp[0] = s0_if.bresp; s_bresp[1] = s1_if.bresp;
    s_rresp[0] = s0_if.rresp; s_rresp[1] = s1_if.rresp;
    s_rdata[0] = s0_if.rdata; s_rdata[1] = s1_if.rdata;
  endtask

  task automatic check_cycle();
    logic [1:0] ewg, erg;
    ewg = (pwg == 0) ? winner(pwreq, lw) : (pbhs ? 2'b00 : pwg);
    erg = (prg == 0) ? winner(prreq, lr) : (prhs ? 2'b00 : prg);
    chk("wr_grant", wr_grant, ewg);
    chk("rd_grant", rd_grant, erg);
    chk("busy", busy, |{ewg, erg});
    mhs_aw = m_if.awvalid & m_if.awready;
    mhs_w  = m_if.wvalid & m_if.wready;
    mhs_b  = m_if.bvalid & m_if.bready;
    mhs_ar = m_if.arvalid & m_if.arready;
    mhs_r  = m_if.rvalid & m_if.rready;
    cap_aw = m_if.awaddr;
    cap_ar = m_if.araddr;
    if (mhs_aw) chk("dup_aw", sw_aw, 0);
    if (mhs_w) chk("dup_w", sw_w, 0);
    if (mhs_ar) chk("dup_ar", sr_ar, 0);
    if (ewg == 0) chk("m_wr_idle", {m_if.awvalid, m_if.wvalid}, 0);
    if (erg == 0) chk("m_rd_idle", m_if.arvalid, 0);
    for (int p = 0; p < 2; p++) begin
      hs_aw[p] = w_awv[p] & s_awr[p];
      hs_w[p]  = w_wv[p] & s_wr[p];
      hs_b[p]  = s_bv[p] & w_bry[p];
      hs_ar[p] = r_arv[p] & s_arr[p];
      hs_r[p]  = s_rv[p] & r_rry[p];
      if (!ewg[p]) begin
        chk("wr_iso", {s_awr[p], s_wr[p], s_bv[p], s_bresp[p]}, 0);
      end else begin
        chk("m_awvalid", m_if.awvalid, w_awv[p]);
        if (w_awv[p]) begin
          chk("m_awaddr", m_if.awaddr, w_addr[p]);
          chk("m_awprot", m_if.awprot, w_prot[p]);
        end
        chk("m_wvalid", m_if.wvalid, w_wv[p]);
        if (w_wv[p]) begin
          chk("m_wdata", m_if.wdata, w_data[p]);
          chk("m_wstrb", m_if.wstrb, w_strb[p]);
        end
        chk("awready", s_awr[p], m_if.awready & ~w_awd[p]);
        chk("wready", s_wr[p], m_if.wready & ~w_wd[p]);
        chk("bvalid", s_bv[p], sw_bv);
        if (sw_bv) begin
          chk("bresp", s_bresp[p], bresp_of(w_addr[p]));
          chk("m_bready", m_if.bready, w_bry[p]);
        end
      end
      if (hs_b[p]) chk("b_after_aw_w", {w_awd[p], w_wd[p]}, 2'b11);
      if (!erg[p]) begin
        chk("rd_iso", {s_arr[p], s_rv[p], s_rresp[p], s_rdata[p]}, 0);
      end else begin
        chk("m_arvalid", m_if.arvalid, r_arv[p]);
        if (r_arv[p]) begin
          chk("m_araddr", m_if.araddr, r_addr[p]);
          chk("m_arprot", m_if.arprot, r_prot[p]);
        end
        chk("arready", s_arr[p], m_if.arready & ~r_ard[p]);
        chk("rvalid", s_rv[p], sr_rv);
        if (sr_rv) begin
          chk("rdata", s_rdata[p], rdata_of(r_addr[p]));
          chk("rresp", s_rresp[p], rresp_of(r_addr[p]));
          chk("m_rready", m_if.rready, r_rry[p]);
        end
      end
      if (hs_r[p]) chk("r_after_ar", r_ard[p], 1);
    end
    pwg = ewg; pwreq = w_awv; pbhs = |hs_b;
    prg = erg; prreq = r_arv; prhs = |hs_r;
    if (hs_b[0]) lw = 0;
    if (hs_b[1]) lw = 1;
    if (hs_r[0]) lr = 0;
    if (hs_r[1]) lr = 1;
  endtask

  task automatic update();
    for (int p = 0; p < 2; p++) begin
      if (hs_aw[p]) begin w_awv[p] = 0; w_awd[p] = 1; end
      if (hs_w[p]) begin w_wv[p] = 0; w_wd[p] = 1; end
      if (hs_b[p]) begin w_act[p] = 0; w_cmp[p]++; end
      if (hs_ar[p]) begin r_arv[p] = 0; r_ard[p] = 1; end
      if (hs_r[p]) begin r_act[p] = 0; r_cmp[p]++; end
      if (gen_on && !w_act[p] && $urandom_range(2) == 0)
        start_wr(p, $urandom_range(3), $urandom_range(3));
      if (gen_on && !r_act[p] && $urandom_range(2) == 0)
        start_rd(p, $urandom_range(3));
    end
    if (mhs_b) begin sw_bv = 0; sw_aw = 0; sw_w = 0; end
    if (mhs_aw) begin sw_aw = 1; sw_addr = cap_aw; end
    if (mhs_w) sw_w = 1;
    if (sw_aw && sw_w && !sw_bv && !sw_hold && $urandom_range(1) == 1)
      sw_bv = 1;
    if (mhs_r) begin sr_rv = 0; sr_ar = 0; end
    if (mhs_ar) begin sr_ar = 1; sr_addr = cap_ar; end
    if (sr_ar && !sr_rv && $urandom_range(1) == 1) sr_rv = 1;
    sw_awr = 1'($urandom_range(1));
    sw_wr  = 1'($urandom_range(1));
    sr_arr = 1'($urandom_range(1));
    advance();
    drive();
  endtask

  task automatic cycle();
    @(negedge clk);
    sample();
    check_cycle();
    @(posedge clk);
    #1;
    update();
  endtask

  task automatic drain();
    int n = 0;
    gen_on = 0;
    sw_hold = 0;
    while ((w_act != 0 || r_act != 0) && n < 400) begin
      cycle();
      n++;
    end
    chk("drain_done", {w_act, r_act}, 0);
  endtask

  task automatic reset_seq();
    reset_model();
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    gen_on = 0;
    sw_hold = 0;
    for (int p = 0; p < 2; p++) begin
      w_iss[p] = 0; w_cmp[p] = 0; r_iss[p] = 0; r_cmp[p] = 0;
    end
    reset_model();
    drive();
    #12;
    chk("rst_wr_grant", wr_grant, 0);
    chk("rst_rd_grant", rd_grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m_valid", {m_if.awvalid, m_if.wvalid, m_if.arvalid}, 0);
    reset_seq();

    // all four requests in the same cycle
    start_wr(0, 0, 0);
    start_wr(1, 0, 0);
    start_rd(0, 0);
    start_rd(1, 0);
    advance();
    drive();
    cycle();
    chk("first_wr_grant", wr_grant, 2'b01);
    chk("first_rd_grant", rd_grant, 2'b01);

    gen_on = 1;
    repeat (3000) cycle();
    drain();
    for (int p = 0; p < 2; p++) begin
      chk("wr_count", w_cmp[p], w_iss[p]);
      chk("rd_count", r_cmp[p], r_iss[p]);
      chk("wr_served", w_cmp[p] > 1, 1);
      chk("rd_served", r_cmp[p] > 1, 1);
    end

    // reset while a port 1 write sits waiting for B
    sw_hold = 1;
    start_wr(1, 0, 3);
    advance();
    drive();
    n = 0;
    while (!(sw_aw && sw_w) && n < 100) begin
      cycle();
      n++;
    end
    chk("reach_resp", {sw_aw, sw_w}, 2'b11);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_grant", wr_grant, 0);
    chk("mid_rst_rd_grant", rd_grant, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_m_valid",
        {m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.bready}, 0);
    chk("mid_rst_s1_rdy", {s1_if.awready, s1_if.wready}, 0);
    sw_hold = 0;
    reset_seq();
    start_wr(0, 0, 0);
    start_wr(1, 0, 0);
    advance();
    drive();
    cycle();
    chk("post_rst_grant", wr_grant, 2'b01);
    drain();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/taxi_axil_arb_2to1.md
Name: taxi_axil_arb_2to1

Overview:
Two-master to one-slave AXI4-Lite arbiter. It shares one register-space AXI-lite slave between the I2C slave bridge (taxi_i2c_slave_axil_master m_axil, port 0) and a host/CPU master (port 1).
- Write and read channels are arbitrated independently.
- Each channel has exactly one outstanding transaction.
- Each channel is round-robin or fixed-priority, selected by parameter.

Parameters:
ARB_RR, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 wins ties.
DATA_W/ADDR_W/STRB_W: not parameters. Taken from the connected taxi_axil_if instances; all three interfaces must match.

Ports:
clk  input  1  clock; all logic on rising edge.
rst_n  input  1  reset, asynchronous assert, active-low; internal release synchronised to clk.
s0_axil_wr  taxi_axil_if.wr_slv  -  write channels from port 0 (I2C bridge).
s0_axil_rd  taxi_axil_if.rd_slv  -  read channels from port 0.
s1_axil_wr  taxi_axil_if.wr_slv  -  write channels from port 1 (host).
s1_axil_rd  taxi_axil_if.rd_slv  -  read channels from port 1.
m_axil_wr  taxi_axil_if.wr_mst  -  shared write channels to the slave.
m_axil_rd  taxi_axil_if.rd_mst  -  shared read channels to the slave.
wr_grant  output  2  one-hot owner of the write channel; 0 when idle.
rd_grant  output  2  one-hot owner of the read channel; 0 when idle.
busy  output  1  |wr_grant | |rd_grant.

Behaviour:
- Reset values (rst_n low): wr_grant=0, rd_grant=0, busy=0.
  - All m valids and all s readies are 0.
  - Both channel FSMs are in IDLE.
  - Round-robin pointer last=1, so port 0 wins the first tie.
- Write FSM states: IDLE -> ADDR -> RESP -> IDLE.
  - IDLE: a port requests when its awvalid=1 (wvalid not required). Pick a winner the same cycle, register wr_grant, go to ADDR. With no request, stay in IDLE.
  - ADDR: forward the granted port's AW and W combinationally to m. Return m awready/wready to the granted port only. Track aw_done and w_done independently, so AW and W may complete in either order or together. Go to RESP when both are done. Once a flag is set, m awvalid/wvalid for that channel is forced to 0.
  - RESP: m bready = granted port's bready. Route bresp/bvalid to the granted port only. On the B handshake: clear wr_grant, update last to the served port, return to IDLE.
- Read FSM states: IDLE -> ADDR -> RESP -> IDLE.
  - The arvalid request rule is the same as for writes.
  - ADDR forwards AR and moves to RESP on the AR handshake.
  - RESP forwards rdata/rresp/rvalid to the granted port and releases on the R handshake.
- Latency: a request seen in cycle N gives m valid in cycle N+1. Minimum turnaround is 1 idle cycle between back-to-back grants (IDLE re-entry).
- The non-granted port sees awready/wready/bvalid/arready/rvalid = 0 and is stalled indefinitely. Its valid/payload must stay stable (AXI rule); the arbiter does not buffer.
- Tie breaking:
  - ARB_RR=1: on a simultaneous request, grant the port != last.
  - ARB_RR=0: port 0 always wins the tie.
  - A single requester is always granted regardless of last.
- The write and read channels never block each other. Port 0 may hold the write channel while port 1 holds the read channel.
- Payloads: addr/prot/data/strb pass through the mux unmodified. Non-granted B/R outputs drive bresp/rresp=0 and rdata=0.
- Reset mid-transaction: everything returns immediately to the reset values. The slave-side transaction is abandoned; the system reset is responsible for the slave.
- No timeout. A slave that never responds holds the grant forever (documented limitation).

Test Plan:
1. Single write from port 0: AW addr=0x0010, W data=0xDEADBEEF strb=0xF -> m AW/W carry the same values one cycle after the request; wr_grant=01; bresp=0 returned to port 0 only; wr_grant=0 after the B handshake.
2. Simultaneous writes from both ports after reset, ARB_RR=1 -> port 0 is served first, then port 1; the m AW addresses appear in order 0x0010 then 0x0020; port 1 awready stays 0 until port 0's B completes.
3. Three back-to-back reads from both ports, ARB_RR=1 -> grant order 0,1,0,1,0,1; each R delivered to the correct port with rdata 0x11111111 for port 0 and 0x22222222 for port 1.
4. W before AW: port 1 asserts wvalid 3 cycles before awvalid; the slave accepts AW first, then W -> exactly one m AW and one m W handshake; bresp=2 (SLVERR) from the slave is reflected to port 1.
5. Concurrent channels: port 0 write and port 1 read in the same cycle -> wr_grant=01 and rd_grant=10 both set one cycle later, with no serialisation.
6. Reset mid-transaction: drop rst_n while in write RESP -> grants=0, m valids=0, busy=0 asynchronously. After release, the next request is granted normally with port 0 preferred.
